// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body engine: direction and state encodings,
// active video limits, and the direction-reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DEAD
  } state_t;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_dir_ctrl.sv
// Steering: u>d>l>r button priority, rejects a 180-degree turn against the applied
// direction, and holds the pending direction taken at the next movement step.
module snake_dir_ctrl
  import snake_pkg::*;
(
  input  logic       clk_d,
  input  logic       rst_n,
  input  logic       reinit,
  input  logic       l,
  input  logic       r,
  input  logic       u,
  input  logic       d,
  input  logic [1:0] cur_dir,
  output logic [1:0] pend_dir
);

  dir_t pend_q;
  dir_t press_dir;
  logic press_vld;

  always_comb begin
    press_vld = 1'b1;
    press_dir = DIR_RIGHT;
    if (u)      press_dir = DIR_UP;
    else if (d) press_dir = DIR_DOWN;
    else if (l) press_dir = DIR_LEFT;
    else if (r) press_dir = DIR_RIGHT;
    else        press_vld = 1'b0;
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n)
      pend_q <= DIR_RIGHT;
    else if (reinit)
      pend_q <= DIR_RIGHT;
    else if (press_vld && (press_dir != reverse_dir(dir_t'(cur_dir))))
      pend_q <= press_dir;
  end

  assign pend_dir = pend_q;

endmodule

// File: rtl/snake_body_engine.sv
// Snake state engine: segment array, game FSM, tick synchroniser, self-hit detection and
// registered per-pixel head/body flags for the current beam cell.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 4,
  parameter int unsigned CELL_SH  = 3,
  parameter int unsigned GRID_W   = 80,
  parameter int unsigned GRID_H   = 60
) (
  input  logic       clk_d,
  input  logic       rst_n,
  input  logic       start,
  input  logic       update_tick,
  input  logic       l,
  input  logic       r,
  input  logic       u,
  input  logic       d,
  input  logic       h,
  input  logic       grow,
  input  logic       freeze,
  input  logic [9:0] x_count,
  input  logic [9:0] y_count,
  output logic       snake_head,
  output logic       snake_body,
  output logic [6:0] head_x,
  output logic [5:0] head_y,
  output logic [4:0] length,
  output logic       dead
);

  state_t     state, state_nx;
  dir_t       dir_q;
  logic [1:0] pend_w;
  dir_t       pend_dir;
  logic [6:0] seg_x [MAX_LEN];
  logic [5:0] seg_y [MAX_LEN];
  logic [4:0] len_q;
  logic       grow_pend;
  logic       tick_s1, tick_s2, tick_s3;
  logic       step_en, growing, hit_any, self_hit;
  logic [6:0] nx;
  logic [5:0] ny;
  logic [9:0] cell_x, cell_y;
  logic       in_act, head_hit, body_hit;
  int unsigned hit_lim;

  assign pend_dir = dir_t'(pend_w);

  snake_dir_ctrl u_dir_ctrl (
    .clk_d    (clk_d),
    .rst_n    (rst_n),
    .reinit   (!start),
    .l        (l),
    .r        (r),
    .u        (u),
    .d        (d),
    .cur_dir  (dir_q),
    .pend_dir (pend_w)
  );

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_s3 <= 1'b0;
    end else begin
      tick_s1 <= update_tick;
      tick_s2 <= tick_s1;
      tick_s3 <= tick_s2;
    end
  end

  assign step_en = tick_s2 && !tick_s3 && (state == ST_RUN) && start;
  assign growing = grow_pend || grow;

  always_comb begin
    nx = seg_x[0];
    ny = seg_y[0];
    case (pend_dir)
      DIR_UP:    ny = (seg_y[0] == '0) ? 6'(GRID_H - 1) : seg_y[0] - 6'd1;
      DIR_DOWN:  ny = (32'(seg_y[0]) == GRID_H - 1) ? '0 : seg_y[0] + 6'd1;
      DIR_LEFT:  nx = (seg_x[0] == '0) ? 7'(GRID_W - 1) : seg_x[0] - 7'd1;
      default:   nx = (32'(seg_x[0]) == GRID_W - 1) ? '0 : seg_x[0] + 7'd1;
    endcase
  end

  // The tail cell is vacated by this step unless the snake grows, so it is excluded then.
  always_comb begin
    hit_lim = growing ? 32'(len_q) : 32'(len_q) - 1;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      if (i < hit_lim && seg_x[i] == nx && seg_y[i] == ny)
        hit_any = 1'b1;
  end

  assign self_hit = step_en && hit_any;

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 7'(GRID_W / 2 - i);
        seg_y[i] <= 6'(GRID_H / 2);
      end
      len_q     <= 5'(INIT_LEN);
      dir_q     <= DIR_RIGHT;
      grow_pend <= 1'b0;
    end else if (!start) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 7'(GRID_W / 2 - i);
        seg_y[i] <= 6'(GRID_H / 2);
      end
      len_q     <= 5'(INIT_LEN);
      dir_q     <= DIR_RIGHT;
      grow_pend <= 1'b0;
    end else if (step_en) begin
      dir_q <= pend_dir;
      for (int unsigned i = 1; i < MAX_LEN; i++) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
      seg_x[0]  <= nx;
      seg_y[0]  <= ny;
      grow_pend <= 1'b0;
      if (growing && 32'(len_q) < MAX_LEN)
        len_q <= len_q + 5'd1;
    end else if (grow && state != ST_IDLE) begin
      grow_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!start)
      state_nx = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  state_nx = ST_RUN;
        ST_RUN: begin
          if (self_hit || freeze) state_nx = ST_DEAD;
          else if (h)             state_nx = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (freeze)  state_nx = ST_DEAD;
          else if (!h) state_nx = ST_RUN;
        end
        default:  state_nx = ST_DEAD;
      endcase
    end
  end

  always_comb begin
    dead = (state == ST_DEAD);
  end

  always_comb begin
    cell_x   = x_count >> CELL_SH;
    cell_y   = y_count >> CELL_SH;
    in_act   = (32'(x_count) < H_ACTIVE) && (32'(y_count) < V_ACTIVE);
    head_hit = in_act && (10'(seg_x[0]) == cell_x) && (10'(seg_y[0]) == cell_y);
    body_hit = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++)
      if (i < 32'(len_q) && (10'(seg_x[i]) == cell_x) && (10'(seg_y[i]) == cell_y))
        body_hit = in_act;
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      snake_head <= 1'b0;
      snake_body <= 1'b0;
    end else begin
      snake_head <= head_hit;
      snake_body <= body_hit && !head_hit;
    end
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = len_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed game scenarios plus random steering/growth, checked
// against a queue-based model of the snake built from the game rules.
module tb_snake_body_engine;

  logic       clk_d = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       update_tick = 1'b0;
  logic       l = 1'b0, r = 1'b0, u = 1'b0, d = 1'b0;
  logic       h = 1'b0, grow = 1'b0, freeze = 1'b0;
  logic [9:0] x_count = '0, y_count = '0;
  logic       snake_head, snake_body, dead;
  logic [6:0] head_x;
  logic [5:0] head_y;
  logic [4:0] length;

  snake_body_engine #(.MAX_LEN(16), .INIT_LEN(4), .CELL_SH(3), .GRID_W(80), .GRID_H(60)) dut (
    .clk_d(clk_d), .rst_n(rst_n), .start(start), .update_tick(update_tick),
    .l(l), .r(r), .u(u), .d(d), .h(h), .grow(grow), .freeze(freeze),
    .x_count(x_count), .y_count(y_count),
    .snake_head(snake_head), .snake_body(snake_body),
    .head_x(head_x), .head_y(head_y), .length(length), .dead(dead)
  );

  always #5 clk_d = ~clk_d;

  int total = 0;
  int bad   = 0;

  // Model: queue of active cells, head first. Directions 0=up 1=down 2=left 3=right.
  // States 0=idle 1=run 2=pause 3=dead.
  int mx[$], my[$];
  int mlen, mdir, mpend, mgp, mstate;
  int dx_t[4]  = '{0, 0, -1, 1};
  int dy_t[4]  = '{-1, 1, 0, 0};
  int rev_t[4] = '{1, 0, 3, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reinit();
    mx = {};
    my = {};
    for (int i = 0; i < 4; i++) begin
      mx.push_back(40 - i);
      my.push_back(30);
    end
    mlen = 4; mdir = 3; mpend = 3; mgp = 0; mstate = 0;
  endtask

  task automatic model_steer(input logic [3:0] mask);
    int p;
    p = -1;
    if (mask[3])      p = 0;
    else if (mask[2]) p = 1;
    else if (mask[1]) p = 2;
    else if (mask[0]) p = 3;
    if (p >= 0 && p != rev_t[mdir]) mpend = p;
  endtask

  task automatic model_step();
    int nx, ny, lim;
    bit hit;
    if (mstate != 1) return;
    mdir = mpend;
    nx = (mx[0] + dx_t[mdir] + 80) % 80;
    ny = (my[0] + dy_t[mdir] + 60) % 60;
    lim = mgp ? mlen : mlen - 1;
    hit = 0;
    for (int i = 0; i < lim; i++)
      if (mx[i] == nx && my[i] == ny) hit = 1;
    mx.push_front(nx);
    my.push_front(ny);
    if (mgp && mlen < 16) mlen++;
    while (mx.size() > mlen) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    mgp = 0;
    if (hit) mstate = 3;
  endtask

  task automatic steer(input logic [3:0] mask);
    @(negedge clk_d);
    {u, d, l, r} = mask;
    repeat (2) @(negedge clk_d);
    {u, d, l, r} = 4'b0;
    model_steer(mask);
  endtask

  task automatic tick();
    @(negedge clk_d);
    update_tick = 1'b1;
    repeat (4) @(negedge clk_d);
    update_tick = 1'b0;
    repeat (3) @(negedge clk_d);
    model_step();
  endtask

  task automatic pulse_grow();
    @(negedge clk_d);
    grow = 1'b1;
    @(negedge clk_d);
    grow = 1'b0;
    if (mstate != 0) mgp = 1;
  endtask

  task automatic set_start(input logic v);
    @(negedge clk_d);
    start = v;
    repeat (2) @(negedge clk_d);
    if (!v) model_reinit();
    else if (mstate == 0) mstate = 1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_hx"}, 32'(head_x), mx[0]);
    chk({tag, "_hy"}, 32'(head_y), my[0]);
    chk({tag, "_len"}, 32'(length), mlen);
    chk({tag, "_dead"}, 32'(dead), 32'(mstate == 3));
  endtask

  task automatic check_cell(input string tag, input int cx, input int cy);
    bit eh, eb;
    @(negedge clk_d);
    x_count = 10'(cx * 8 + int'($urandom_range(0, 7)));
    y_count = 10'(cy * 8 + int'($urandom_range(0, 7)));
    @(negedge clk_d);
    eh = (cx == mx[0] && cy == my[0]);
    eb = 0;
    for (int i = 1; i < mlen; i++)
      if (mx[i] == cx && my[i] == cy) eb = 1;
    eb = eb && !eh;
    chk({tag, "_shead"}, 32'(snake_head), 32'(eh));
    chk({tag, "_sbody"}, 32'(snake_body), 32'(eb));
  endtask

  task automatic check_render(input string tag);
    check_cell({tag, "_h"}, mx[0], my[0]);
    check_cell({tag, "_b1"}, mx[1], my[1]);
    check_cell({tag, "_bt"}, mx[mlen-1], my[mlen-1]);
    check_cell({tag, "_rnd"}, int'($urandom_range(0, 79)), int'($urandom_range(0, 59)));
  endtask

  initial begin
    model_reinit();
    repeat (3) @(negedge clk_d);
    check_state("reset");
    chk("reset_shead", 32'(snake_head), 0);
    chk("reset_sbody", 32'(snake_body), 0);
    @(negedge clk_d);
    rst_n = 1'b1;
    set_start(1'b1);

    repeat (3) tick();
    check_state("run3");
    chk("run3_x43", 32'(head_x), 43);
    check_cell("body42", 42, 30);

    steer(4'b0010);
    tick();
    check_state("rev_l");
    steer(4'b1000);
    tick();
    check_state("up");

    steer(4'b0001);
    for (int k = 0; k < 100 && mx[0] != 79; k++) tick();
    check_state("at79");
    tick();
    check_state("wrap");
    chk("wrap_x0", 32'(head_x), 0);

    pulse_grow();
    tick();
    check_state("grow5");
    repeat (13) begin
      pulse_grow();
      tick();
    end
    check_state("sat16");
    check_render("len16");

    set_start(1'b0);
    check_state("idle");
    set_start(1'b1);

    pulse_grow();
    tick();
    steer(4'b1000); tick();
    steer(4'b0010); tick();
    steer(4'b0100); tick();
    check_state("selfhit");
    check_render("dead");
    set_start(1'b0);
    check_state("rearm");
    set_start(1'b1);

    for (int it = 0; it < 40; it++) begin
      logic [3:0] mask;
      mask = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      if (mask != 4'b0) steer(mask);
      if ($urandom_range(0, 3) == 0) pulse_grow();
      tick();
      check_state("rnd");
      if (it % 8 == 0) check_render("rnd");
      if (mstate == 3) begin
        set_start(1'b0);
        set_start(1'b1);
      end
    end

    @(negedge clk_d);
    h = 1'b1;
    repeat (2) @(negedge clk_d);
    mstate = 2;
    tick();
    check_state("pause");
    @(negedge clk_d);
    h = 1'b0;
    repeat (2) @(negedge clk_d);
    mstate = 1;
    tick();
    check_state("resume");

    @(negedge clk_d);
    freeze = 1'b1;
    @(negedge clk_d);
    freeze = 1'b0;
    @(negedge clk_d);
    mstate = 3;
    check_state("freeze");
    tick();
    check_state("dead_hold");

    @(negedge clk_d);
    x_count = 10'd640;
    y_count = 10'(my[0] * 8);
    @(negedge clk_d);
    chk("x640_shead", 32'(snake_head), 0);
    chk("x640_sbody", 32'(snake_body), 0);
    x_count = 10'(mx[0] * 8);
    y_count = 10'd480;
    @(negedge clk_d);
    chk("y480_shead", 32'(snake_head), 0);
    chk("y480_sbody", 32'(snake_body), 0);

    set_start(1'b0);
    set_start(1'b1);
    tick();
    tick();
    check_state("pre_rst");
    x_count = 10'(mx[0] * 8);
    y_count = 10'(my[0] * 8);
    @(negedge clk_d);
    update_tick = 1'b1;
    @(posedge clk_d);
    @(posedge clk_d);
    #1 rst_n = 1'b0;
    #1 model_reinit();
    check_state("mid_rst");
    chk("mid_rst_shead", 32'(snake_head), 0);
    chk("mid_rst_sbody", 32'(snake_body), 0);
    update_tick = 1'b0;
    repeat (3) @(negedge clk_d);
    check_state("rst_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
